instr_fetch: RTL

Fetch stage directly upstream of the instruction ROM. Owns the PC, drives the ROM word address, read enable and chip enable, and captures the 32-bit ROM data into a 2-entry buffer. Presents {instr, pc} to decode over a valid/ready handshake. Supports start, halt and branch/jump redirect with flush.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_buf.sv | 69 ++++++
 rtl/instr_fetch.sv | 114 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int INSTR_W   = 32;
  localparam int PC_STEP   = 4;
  localparam int BUF_CNT_W = 2;

  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry FIFO of {instr, pc}. Entry 0 is always the head, so the
// head outputs keep their last value once the buffer runs empty or is flushed.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 flush,
  input  logic [INSTR_W-1:0]   push_instr,
  input  logic [XLEN-1:0]      push_pc,
  output logic [BUF_CNT_W-1:0] count,
  output logic                 head_valid,
  output logic [INSTR_W-1:0]   head_instr,
  output logic [XLEN-1:0]      head_pc
);

  localparam logic [BUF_CNT_W-1:0] EMPTY = BUF_CNT_W'(0);
  localparam logic [BUF_CNT_W-1:0] ONE   = BUF_CNT_W'(1);
  localparam logic [BUF_CNT_W-1:0] FULL  = BUF_CNT_W'(2);

  logic [INSTR_W-1:0] instr0, instr1;
  logic [XLEN-1:0]    pc0, pc1;
  logic               pop_ok, push_ok, push_to_head;

  assign pop_ok       = pop && (count != EMPTY);
  assign push_ok      = push && ((count != FULL) || pop_ok);
  assign push_to_head = (count == EMPTY) || ((count == ONE) && pop_ok);

  // Storage and occupancy; flush only clears the count so the head holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= EMPTY;
      instr0 <= '0;
      pc0    <= '0;
      instr1 <= '0;
      pc1    <= '0;
    end else if (flush) begin
      count <= EMPTY;
    end else begin
      if (pop_ok && (count == FULL)) begin
        instr0 <= instr1;
        pc0    <= pc1;
      end
      if (push_ok) begin
        if (push_to_head) begin
          instr0 <= push_instr;
          pc0    <= push_pc;
        end else begin
          instr1 <= push_instr;
          pc1    <= push_pc;
        end
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  assign head_valid = (count != EMPTY);
  assign head_instr = instr0;
  assign head_pc    = pc0;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC and fetch state machine, reads the instruction ROM
// and hands {instr, pc} to decode through fetch_buf.
// Build option FETCH_MISALIGN_CHK_EN adds a sticky fetch_fault output raised
// by a misaligned redirect; without it the redirect target is word-aligned.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              ROM_ADDR_W = 8,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  halt_req,
  input  logic                  redirect_valid,
  input  logic [XLEN-1:0]       redirect_pc,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  output logic                  rom_re,
  output logic                  rom_ce,
  input  logic [INSTR_W-1:0]    rom_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INSTR_W-1:0]    out_instr,
  output logic [XLEN-1:0]       out_pc,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic                  fetch_fault,
`endif
  output logic                  busy
);

  state_t                 state;
  logic [XLEN-1:0]        pc;
  logic [XLEN-1:0]        redir_target;
  logic [BUF_CNT_W-1:0]   count;
  logic                   redir, start_ok, misalign;
  logic                   pop, issue, buf_full;

`ifdef FETCH_MISALIGN_CHK_EN
  logic fault;

  assign redir        = redirect_valid && !fault;
  assign start_ok     = start && !fault;
  assign misalign     = (redirect_pc[1:0] != 2'b00);
  assign redir_target = redirect_pc;
  assign fetch_fault  = fault;

  // Sticky fault: once a misaligned target is taken, only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault <= 1'b0;
    end else if (redir && misalign) begin
      fault <= 1'b1;
    end
  end
`else
  assign redir        = redirect_valid;
  assign start_ok     = start;
  assign misalign     = 1'b0;
  assign redir_target = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
`endif

  // A redirect discards this cycle's handshake and blocks the fetch.
  assign buf_full = (int'(count) == BUF_DEPTH);
  assign pop      = out_valid && out_ready && !redir;
  assign issue    = (state == RUN) && !redir && (!buf_full || pop);

  assign rom_addr = pc[ROM_ADDR_W+1:2];
  assign rom_re   = issue;
  assign rom_ce   = issue;
  assign busy     = (state == RUN);

  // State machine and PC: redirect outranks fetch, halt and start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else if (redir) begin
      pc <= redir_target;
      if (halt_req || misalign) begin
        state <= HALT;
      end else begin
        state <= RUN;
      end
    end else begin
      if (issue) begin
        pc <= pc + XLEN'(PC_STEP);
      end
      case (state)
        IDLE:    if (start_ok) state <= RUN;
        RUN:     if (halt_req) state <= HALT;
        default: state <= state;
      endcase
    end
  end

  fetch_buf #(
    .XLEN (XLEN)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (issue),
    .pop        (pop),
    .flush      (redir),
    .push_instr (rom_data),
    .push_pc    (pc),
    .count      (count),
    .head_valid (out_valid),
    .head_instr (out_instr),
    .head_pc    (out_pc)
  );

endmodule
